hood_mode_scheduler: RTL and testbench

Mode-sequencing controller for the kitchen-hood fan datapath. Consumes debounced single-cycle button pulses, the machine-on level from the on/off controller and a 1 Hz tick; produces the `mode_state` code that drives the smoker/display path, plus a seconds countdown and mode LEDs. It enforces the menu-arming rule, the once-per-power-on hurricane limit with its timed fallback, the hurricane exit delay and the timed self-clean cycle.

---
 rtl/hood_pkg.sv | 41 ++++
 rtl/sec_countdown.sv | 28 ++
 rtl/hood_mode_scheduler.sv | 175 +++++++++++++++++
 tb/tb_hood_mode_scheduler.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/hood_pkg.sv
// Purpose: shared mode codes, state enum, LED bit positions and default durations for the hood scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hood_pkg;

  // Mode codes as seen on mode_state
  localparam logic [2:0] MODE_STANDBY = 3'b000;
  localparam logic [2:0] MODE_L1      = 3'b001;
  localparam logic [2:0] MODE_L2      = 3'b010;
  localparam logic [2:0] MODE_L3      = 3'b011;
  localparam logic [2:0] MODE_CLEAN   = 3'b100;
  localparam logic [2:0] MODE_EXIT    = 3'b101;

  // State encoding equals the external mode code so mode_state is the state register itself
  typedef enum logic [2:0] {
    ST_STANDBY    = MODE_STANDBY,
    ST_MODE1      = MODE_L1,
    ST_MODE2      = MODE_L2,
    ST_MODE3      = MODE_L3,
    ST_CLEAN      = MODE_CLEAN,
    ST_EXIT_DELAY = MODE_EXIT
  } state_t;

  // LED bit positions
  localparam int LED_L1    = 0;
  localparam int LED_L2    = 1;
  localparam int LED_L3    = 2;
  localparam int LED_CLEAN = 3;
  localparam int LED_ARMED = 4;

  // Default durations in seconds (valid range 1..255)
  localparam int unsigned DEF_HURRICANE_SEC  = 60;
  localparam int unsigned DEF_EXIT_DELAY_SEC = 60;
  localparam int unsigned DEF_CLEAN_SEC      = 180;

  // States in which the shared countdown is live and ticks matter
  function automatic logic is_timed(input state_t s);
    return (s == ST_MODE3) || (s == ST_EXIT_DELAY) || (s == ST_CLEAN);
  endfunction

endpackage

// File: rtl/sec_countdown.sv
// Purpose: 8-bit seconds down-counter with synchronous load; flags the tick that takes it from 1 to 0.
// Latency: load/decrement visible one cycle after the edge; expire is combinational from value and tick.
// Backpressure: none; load has priority over tick, and the count saturates at 0.
module sec_countdown (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       tick,
  output logic [7:0] value,
  output logic       expire
);

  // The owner gives a coincident load priority over expiry, so expire only looks at tick and value
  assign expire = tick && (value == 8'd1);

  // Load wins over tick; decrement never goes below zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= 8'd0;
    end else if (load) begin
      value <= load_val;
    end else if (tick && (value != 8'd0)) begin
      value <= value - 8'd1;
    end
  end

endmodule

// File: rtl/hood_mode_scheduler.sv
// Purpose: kitchen-hood mode sequencer (menu arming, one-shot hurricane with timed fallback, exit delay, self-clean).
// Latency: one cycle from a sampled button/tick to mode_state and remaining_sec; led is combinational from state.
// Backpressure: none; inputs are single-cycle pulses, simultaneous events resolved by fixed priority.
module hood_mode_scheduler
  import hood_pkg::*;
#(
  parameter int unsigned HURRICANE_SEC  = DEF_HURRICANE_SEC,
  parameter int unsigned EXIT_DELAY_SEC = DEF_EXIT_DELAY_SEC,
  parameter int unsigned CLEAN_SEC      = DEF_CLEAN_SEC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       machine_on,
  input  logic       tick_1hz,
  input  logic       menu_btn,
  input  logic       mode1_btn,
  input  logic       mode2_btn,
  input  logic       mode3_btn,
  input  logic       clean_btn,
  output logic [2:0] mode_state,
  output logic [7:0] remaining_sec,
  output logic       hurricane_used,
  output logic       clean_done,
  output logic [4:0] led
);

  localparam logic [7:0] HURRICANE_LD = 8'(HURRICANE_SEC);
  localparam logic [7:0] EXIT_LD      = 8'(EXIT_DELAY_SEC);
  localparam logic [7:0] CLEAN_LD     = 8'(CLEAN_SEC);

  state_t     state, state_nxt;
  logic       menu_armed, armed_nxt;
  logic       hurr_nxt;
  logic       done_nxt;
  logic       cnt_load;
  logic [7:0] cnt_load_val;
  logic       cnt_tick;
  logic       cnt_expire;

  // Ticks only reach the counter while a timed state owns it
  assign cnt_tick = tick_1hz && is_timed(state);

  sec_countdown u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .tick     (cnt_tick),
    .value    (remaining_sec),
    .expire   (cnt_expire)
  );

  assign mode_state = state;

  // Register state, arm flag, hurricane latch and the completion pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_STANDBY;
      menu_armed     <= 1'b0;
      hurricane_used <= 1'b0;
      clean_done     <= 1'b0;
    end else begin
      state          <= state_nxt;
      menu_armed     <= armed_nxt;
      hurricane_used <= hurr_nxt;
      clean_done     <= done_nxt;
    end
  end

  // Next-state decode: power-off first, then buttons in priority order, then timer expiry
  always_comb begin
    state_nxt    = state;
    armed_nxt    = 1'b0;
    hurr_nxt     = hurricane_used;
    done_nxt     = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = 8'd0;

    if (!machine_on) begin
      // Power-off wipes the timer and the hurricane allowance without a clean_done pulse
      state_nxt    = ST_STANDBY;
      hurr_nxt     = 1'b0;
      cnt_load     = 1'b1;
      cnt_load_val = 8'd0;
    end else begin
      case (state)
        ST_STANDBY: begin
          armed_nxt = menu_armed;
          if (menu_btn) begin
            armed_nxt = !menu_armed;
          end else if (menu_armed) begin
            if (mode1_btn) begin
              state_nxt = ST_MODE1;
              armed_nxt = 1'b0;
            end else if (mode2_btn) begin
              state_nxt = ST_MODE2;
              armed_nxt = 1'b0;
            end else if (mode3_btn && !hurricane_used) begin
              state_nxt    = ST_MODE3;
              armed_nxt    = 1'b0;
              hurr_nxt     = 1'b1;
              cnt_load     = 1'b1;
              cnt_load_val = HURRICANE_LD;
            end else if (clean_btn) begin
              state_nxt    = ST_CLEAN;
              armed_nxt    = 1'b0;
              cnt_load     = 1'b1;
              cnt_load_val = CLEAN_LD;
            end
          end
        end

        ST_MODE1, ST_MODE2: begin
          if (menu_btn) begin
            state_nxt = ST_STANDBY;
          end else if (mode1_btn) begin
            state_nxt = ST_MODE1;
          end else if (mode2_btn) begin
            state_nxt = ST_MODE2;
          end else if (mode3_btn && !hurricane_used) begin
            state_nxt    = ST_MODE3;
            hurr_nxt     = 1'b1;
            cnt_load     = 1'b1;
            cnt_load_val = HURRICANE_LD;
          end
        end

        ST_MODE3: begin
          // Menu beats a coincident tick: the exit delay loads in full
          if (menu_btn) begin
            state_nxt    = ST_EXIT_DELAY;
            cnt_load     = 1'b1;
            cnt_load_val = EXIT_LD;
          end else if (cnt_expire) begin
            state_nxt = ST_MODE2;
          end
        end

        ST_EXIT_DELAY: begin
          if (cnt_expire) begin
            state_nxt = ST_STANDBY;
          end
        end

        ST_CLEAN: begin
          if (cnt_expire) begin
            state_nxt = ST_STANDBY;
            done_nxt  = 1'b1;
          end
        end

        default: begin
          state_nxt    = ST_STANDBY;
          cnt_load     = 1'b1;
          cnt_load_val = 8'd0;
        end
      endcase
    end
  end

  // LED map: one-hot mode bits, L2 lamp also during exit delay, armed lamp from the flag
  always_comb begin
    led = 5'b00000;
    case (state)
      ST_MODE1:      led[LED_L1]    = 1'b1;
      ST_MODE2:      led[LED_L2]    = 1'b1;
      ST_EXIT_DELAY: led[LED_L2]    = 1'b1;
      ST_MODE3:      led[LED_L3]    = 1'b1;
      ST_CLEAN:      led[LED_CLEAN] = 1'b1;
      default:       led            = 5'b00000;
    endcase
    led[LED_ARMED] = menu_armed;
  end

endmodule

// File: tb/tb_hood_mode_scheduler.sv
module tb_hood_mode_scheduler;

  localparam int H_SEC = 3;
  localparam int E_SEC = 4;
  localparam int C_SEC = 2;

  localparam logic [4:0] B_NONE = 5'b00000;
  localparam logic [4:0] B_MENU = 5'b00001;
  localparam logic [4:0] B_M1   = 5'b00010;
  localparam logic [4:0] B_M2   = 5'b00100;
  localparam logic [4:0] B_M3   = 5'b01000;
  localparam logic [4:0] B_CL   = 5'b10000;

  logic       clk = 1'b0;
  logic       rst;
  logic       machine_on;
  logic       tick_1hz;
  logic       menu_btn, mode1_btn, mode2_btn, mode3_btn, clean_btn;
  logic [2:0] mode_state;
  logic [7:0] remaining_sec;
  logic       hurricane_used;
  logic       clean_done;
  logic [4:0] led;

  int checks   = 0;
  int failures = 0;

  // Reference model state, in plain spec terms
  int m_mode;   // 0 standby, 1 L1, 2 L2, 3 L3, 4 clean, 5 exit delay
  int m_rem;
  bit m_armed;
  bit m_used;
  bit m_done;

  hood_mode_scheduler #(
    .HURRICANE_SEC  (H_SEC),
    .EXIT_DELAY_SEC (E_SEC),
    .CLEAN_SEC      (C_SEC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .machine_on     (machine_on),
    .tick_1hz       (tick_1hz),
    .menu_btn       (menu_btn),
    .mode1_btn      (mode1_btn),
    .mode2_btn      (mode2_btn),
    .mode3_btn      (mode3_btn),
    .clean_btn      (clean_btn),
    .mode_state     (mode_state),
    .remaining_sec  (remaining_sec),
    .hurricane_used (hurricane_used),
    .clean_done     (clean_done),
    .led            (led)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_rem = 0; m_armed = 0; m_used = 0; m_done = 0;
  endtask

  // One clock edge of the specified behaviour
  task automatic model_step(input bit on, input logic [4:0] b, input bit tk);
    bit menu, m1, m2, m3, cl;
    menu = b[0]; m1 = b[1]; m2 = b[2]; m3 = b[3]; cl = b[4];
    m_done = 0;
    if (!on) begin
      m_mode = 0; m_rem = 0; m_armed = 0; m_used = 0;
    end else if (m_mode == 0) begin
      if (menu) m_armed = !m_armed;
      else if (m_armed) begin
        if (m1)                 begin m_mode = 1; m_armed = 0; end
        else if (m2)            begin m_mode = 2; m_armed = 0; end
        else if (m3 && !m_used) begin m_mode = 3; m_armed = 0; m_rem = H_SEC; m_used = 1; end
        else if (cl)            begin m_mode = 4; m_armed = 0; m_rem = C_SEC; end
      end
    end else if (m_mode == 1 || m_mode == 2) begin
      if (menu)               m_mode = 0;
      else if (m1)            m_mode = 1;
      else if (m2)            m_mode = 2;
      else if (m3 && !m_used) begin m_mode = 3; m_rem = H_SEC; m_used = 1; end
    end else if (m_mode == 3) begin
      if (menu) begin m_mode = 5; m_rem = E_SEC; end
      else if (tk) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) m_mode = 2;
      end
    end else if (tk) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        if (m_mode == 4) m_done = 1;
        m_mode = 0;
      end
    end
  endtask

  task automatic check_all(input string where);
    logic [4:0] e;
    e[0] = (m_mode == 1);
    e[1] = (m_mode == 2) || (m_mode == 5);
    e[2] = (m_mode == 3);
    e[3] = (m_mode == 4);
    e[4] = m_armed;
    chk({where, ".mode_state"}, {5'd0, mode_state}, 8'(m_mode));
    chk({where, ".remaining_sec"}, remaining_sec, 8'(m_rem));
    chk({where, ".hurricane_used"}, {7'd0, hurricane_used}, {7'd0, m_used});
    chk({where, ".clean_done"}, {7'd0, clean_done}, {7'd0, m_done});
    chk({where, ".led"}, {3'd0, led}, {3'd0, e});
  endtask

  // Drive one cycle of inputs, clock it, advance the model and compare
  task automatic cyc(input logic [4:0] b, input logic tk);
    menu_btn = b[0]; mode1_btn = b[1]; mode2_btn = b[2]; mode3_btn = b[3]; clean_btn = b[4];
    tick_1hz = tk;
    @(posedge clk);
    model_step(machine_on, b, tk);
    #1;
    menu_btn = 0; mode1_btn = 0; mode2_btn = 0; mode3_btn = 0; clean_btn = 0; tick_1hz = 0;
    check_all("cyc");
  endtask

  initial begin
    rst = 0; machine_on = 1; tick_1hz = 0;
    menu_btn = 0; mode1_btn = 0; mode2_btn = 0; mode3_btn = 0; clean_btn = 0;
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk); @(negedge clk);
    rst = 1;

    cyc(B_NONE, 0);
    // Unarmed press is ignored
    cyc(B_M2, 0);   chk("unarmed_mode2", {5'd0, mode_state}, 8'd0);
    cyc(B_MENU, 0); chk("armed_led4", {7'd0, led[4]}, 8'd1);
    cyc(B_M2, 0);   chk("armed_mode2", {5'd0, mode_state}, 8'd2);
                    chk("mode2_led", {3'd0, led}, 8'b00010);

    // Hurricane run and timed fallback
    cyc(B_MENU, 0); cyc(B_MENU, 0);
    cyc(B_M3, 0);   chk("l3_entry", {5'd0, mode_state}, 8'd3);
                    chk("l3_load", remaining_sec, 8'd3);
    cyc(B_NONE, 1); chk("l3_t1", remaining_sec, 8'd2);
    cyc(B_NONE, 1); chk("l3_t2", remaining_sec, 8'd1);
    cyc(B_NONE, 1); chk("l3_fallback", {5'd0, mode_state}, 8'd2);
                    chk("l3_used", {7'd0, hurricane_used}, 8'd1);
    cyc(B_MENU, 0); cyc(B_MENU, 0);
    cyc(B_M3, 0);   chk("l3_second_ignored", {5'd0, mode_state}, 8'd0);
                    chk("l3_arm_kept", {7'd0, led[4]}, 8'd1);

    // Power cycle restores the hurricane allowance
    machine_on = 0; cyc(B_NONE, 0);
    chk("off_clears_used", {7'd0, hurricane_used}, 8'd0);
    machine_on = 1;

    // Exit delay, with menu coinciding with a tick
    cyc(B_MENU, 0); cyc(B_M3, 0); cyc(B_NONE, 1);
    cyc(B_MENU, 1); chk("exit_entry", {5'd0, mode_state}, 8'd5);
                    chk("exit_full_load", remaining_sec, 8'(E_SEC));
    for (int i = 0; i < E_SEC - 1; i++) cyc(B_NONE, 1);
    chk("exit_last", remaining_sec, 8'd1);
    cyc(B_NONE, 1); chk("exit_done", {5'd0, mode_state}, 8'd0);

    // Self-clean, not abortable, single done pulse
    cyc(B_MENU, 0);
    cyc(B_CL, 0);   chk("clean_entry", {5'd0, mode_state}, 8'd4);
    cyc(B_MENU, 0); chk("clean_no_abort", {5'd0, mode_state}, 8'd4);
    cyc(B_NONE, 1); chk("clean_no_early_done", {7'd0, clean_done}, 8'd0);
    cyc(B_NONE, 1); chk("clean_exit", {5'd0, mode_state}, 8'd0);
                    chk("clean_done_pulse", {7'd0, clean_done}, 8'd1);
    cyc(B_NONE, 0); chk("clean_done_single", {7'd0, clean_done}, 8'd0);

    // Button with coincident tick in MODE2
    cyc(B_MENU, 0); cyc(B_M2, 0);
    cyc(B_M1, 1);   chk("m2_to_m1_tick", {5'd0, mode_state}, 8'd1);
                    chk("m1_rem_zero", remaining_sec, 8'd0);

    // Power-off during clean
    cyc(B_MENU, 0); cyc(B_MENU, 0); cyc(B_CL, 0);
    machine_on = 0;
    cyc(B_NONE, 1); chk("off_in_clean", {5'd0, mode_state}, 8'd0);
                    chk("off_no_done", {7'd0, clean_done}, 8'd0);
    machine_on = 1;

    // Asynchronous reset mid hurricane countdown
    cyc(B_MENU, 0); cyc(B_M3, 0); cyc(B_NONE, 1);
    #2; rst = 0; #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst_mode", {5'd0, mode_state}, 8'd0);
    @(negedge clk); rst = 1;

    // Randomised traffic against the model
    repeat (3000) begin
      logic [4:0] b;
      logic       tk;
      for (int k = 0; k < 5; k++) b[k] = ($urandom_range(0, 7) == 0);
      tk = ($urandom_range(0, 2) == 0);
      machine_on = ($urandom_range(0, 99) != 0);
      cyc(b, tk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
